regfile_2r1w: RTL and testbench

//  Parametrised register file: DEPTH entries of DATA_WIDTH bits, one write port, two independent read ports.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_clear_seq.sv | 60 ++++++
 rtl/regfile_2r1w.sv | 98 +++++++++
 tb/tb_regfile_2r1w.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and helpers for the 2-read/1-write register file
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // True when an index addresses a real entry; DEPTH need not be a power of two.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// rtl/regfile_clear_seq.sv - background clear sweep sequencer (IDLE/CLEAR FSM plus index counter)
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  clr_en,
    output logic [ADDR_WIDTH-1:0] clr_idx
);

    clr_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;

    // State and sweep index registers; reset returns to IDLE at index 0.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: a request starts a sweep from 0; further requests mid-sweep are ignored.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                if (idx_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign busy    = (state_q == CLEAR);
    assign clr_en  = busy;
    assign clr_idx = idx_q;

endmodule

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - DEPTH x DATA_WIDTH register file, one write port, two registered read ports
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_err,
    input  logic                  rd_en_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic                  rd_valid_a,
    input  logic                  rd_en_b,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  rd_valid_b,
    input  logic                  clear_req,
    output logic                  busy
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  clr_en;
    logic [ADDR_WIDTH-1:0] clr_idx;
    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] rd_next_a, rd_next_b;

    regfile_clear_seq #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_seq (
        .clock     (clock),
        .reset     (reset),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_en    (clr_en),
        .clr_idx   (clr_idx)
    );

    // A write lands only when in range and no sweep owns the array.
    assign wr_ok = wr_en && !busy && addr_in_range(32'(wr_addr), DEPTH);

    // Port A read value: out-of-range reads 0, optional forwarding of a same-cycle write.
    always_comb begin
        rd_next_a = '0;
        if (addr_in_range(32'(rd_addr_a), DEPTH)) begin
            if ((BYPASS != 0) && wr_ok && (rd_addr_a == wr_addr)) rd_next_a = wr_data;
            else rd_next_a = mem[rd_addr_a];
        end
    end

    // Port B read value: same rule as port A, evaluated independently.
    always_comb begin
        rd_next_b = '0;
        if (addr_in_range(32'(rd_addr_b), DEPTH)) begin
            if ((BYPASS != 0) && wr_ok && (rd_addr_b == wr_addr)) rd_next_b = wr_data;
            else rd_next_b = mem[rd_addr_b];
        end
    end

    // Storage: accepted writes and sweep clears never collide because writes drop while busy.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_ok) mem[wr_addr] <= wr_data;
            if (clr_en) mem[clr_idx] <= '0;
        end
    end

    // Read pipelines: data holds when idle, valid pulses only for issued reads.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_data_a  <= '0;
            rd_valid_a <= 1'b0;
            rd_data_b  <= '0;
            rd_valid_b <= 1'b0;
        end else begin
            rd_valid_a <= rd_en_a;
            rd_valid_b <= rd_en_b;
            if (rd_en_a) rd_data_a <= rd_next_a;
            if (rd_en_b) rd_data_b <= rd_next_b;
        end
    end

    // Dropped-write flag, one cycle after the rejected request.
    always_ff @(posedge clock) begin
        if (!reset) wr_err <= 1'b0;
        else        wr_err <= wr_en && !wr_ok;
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - self-checking bench for regfile_2r1w (BYPASS=1, BYPASS=0, DEPTH=12 instances)
module tb_regfile_2r1w;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       rd_en_a = 1'b0;
    logic [3:0] rd_addr_a = '0;
    logic       rd_en_b = 1'b0;
    logic [3:0] rd_addr_b = '0;
    logic       clear_req = 1'b0;

    logic [7:0] rda_o [3];
    logic [7:0] rdb_o [3];
    logic       va_o [3];
    logic       vb_o [3];
    logic       werr_o [3];
    logic       busy_o [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    regfile_2r1w #(.DATA_WIDTH(8), .DEPTH(16), .BYPASS(1)) dut_b1 (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(werr_o[0]), .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rda_o[0]),
        .rd_valid_a(va_o[0]), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rdb_o[0]),
        .rd_valid_b(vb_o[0]), .clear_req(clear_req), .busy(busy_o[0]));

    regfile_2r1w #(.DATA_WIDTH(8), .DEPTH(16), .BYPASS(0)) dut_b0 (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(werr_o[1]), .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rda_o[1]),
        .rd_valid_a(va_o[1]), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rdb_o[1]),
        .rd_valid_b(vb_o[1]), .clear_req(clear_req), .busy(busy_o[1]));

    regfile_2r1w #(.DATA_WIDTH(8), .DEPTH(12), .BYPASS(1)) dut_d12 (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(werr_o[2]), .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rda_o[2]),
        .rd_valid_a(va_o[2]), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rdb_o[2]),
        .rd_valid_b(vb_o[2]), .clear_req(clear_req), .busy(busy_o[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: array contents plus sweep position per instance.
    int         m_depth [3] = '{16, 16, 12};
    int         m_byp [3]   = '{1, 0, 1};
    logic [7:0] m_mem [3][16];
    int         m_pos [3];
    logic [7:0] e_rda [3];
    logic [7:0] e_rdb [3];
    logic       e_va [3];
    logic       e_vb [3];
    logic       e_werr [3];
    logic       e_busy [3];
    bit         acc;

    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset) begin
                for (int j = 0; j < 16; j++) m_mem[i][j] = 8'h00;
                e_rda[i] = 8'h00; e_rdb[i] = 8'h00;
                e_va[i] = 1'b0; e_vb[i] = 1'b0; e_werr[i] = 1'b0;
                m_pos[i] = -1;
            end else begin
                acc = wr_en && (int'(wr_addr) < m_depth[i]) && (m_pos[i] < 0);
                e_va[i] = rd_en_a;
                if (rd_en_a) begin
                    if (int'(rd_addr_a) >= m_depth[i]) e_rda[i] = 8'h00;
                    else if (m_byp[i] != 0 && acc && rd_addr_a == wr_addr) e_rda[i] = wr_data;
                    else e_rda[i] = m_mem[i][rd_addr_a];
                end
                e_vb[i] = rd_en_b;
                if (rd_en_b) begin
                    if (int'(rd_addr_b) >= m_depth[i]) e_rdb[i] = 8'h00;
                    else if (m_byp[i] != 0 && acc && rd_addr_b == wr_addr) e_rdb[i] = wr_data;
                    else e_rdb[i] = m_mem[i][rd_addr_b];
                end
                e_werr[i] = wr_en && !acc;
                if (acc) m_mem[i][wr_addr] = wr_data;
                if (m_pos[i] >= 0) begin
                    m_mem[i][m_pos[i]] = 8'h00;
                    m_pos[i]++;
                    if (m_pos[i] == m_depth[i]) m_pos[i] = -1;
                end else if (clear_req) begin
                    m_pos[i] = 0;
                end
            end
            e_busy[i] = (m_pos[i] >= 0);
        end
    end

    // Every-cycle comparison of all instances against the model.
    always @(posedge clock) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rd_data_a[%0d]", i), 32'(rda_o[i]), 32'(e_rda[i]));
            check($sformatf("rd_data_b[%0d]", i), 32'(rdb_o[i]), 32'(e_rdb[i]));
            check($sformatf("rd_valid_a[%0d]", i), 32'(va_o[i]), 32'(e_va[i]));
            check($sformatf("rd_valid_b[%0d]", i), 32'(vb_o[i]), 32'(e_vb[i]));
            check($sformatf("wr_err[%0d]", i), 32'(werr_o[i]), 32'(e_werr[i]));
            check($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(e_busy[i]));
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic idle_in();
        wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0; clear_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int cnt;
        int k;

        // Reset held for two cycles
        idle_in();
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        check("reset_busy", 32'(busy_o[0]), 0);
        check("reset_wr_err", 32'(werr_o[0]), 0);
        check("reset_rd_valid_a", 32'(va_o[0]), 0);
        check("reset_rd_data_a", 32'(rda_o[0]), 0);

        // Every address reads zero after reset
        for (int a = 0; a < 16; a++) begin
            rd_en_a = 1'b1; rd_addr_a = 4'(a);
            rd_en_b = 1'b1; rd_addr_b = 4'(15 - a);
            step();
            check("t1_rd_a", 32'(rda_o[0]), 0);
            check("t1_rd_b", 32'(rdb_o[0]), 0);
        end
        idle_in();

        // Write then read on both ports
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        rd_en_a = 1'b1; rd_addr_a = 4'd3; rd_en_b = 1'b1; rd_addr_b = 4'd3;
        step();
        check("t2_rd_a", 32'(rda_o[0]), 32'h A5);
        check("t2_rd_b", 32'(rdb_o[0]), 32'h A5);
        check("t2_valid_a", 32'(va_o[0]), 1);
        check("t2_valid_b", 32'(vb_o[0]), 1);
        idle_in();

        // Bypass versus old contents
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h11;
        step();
        wr_data = 8'h22; rd_en_a = 1'b1; rd_addr_a = 4'd5;
        step();
        check("t3_bypass1", 32'(rda_o[0]), 32'h22);
        check("t3_bypass0", 32'(rda_o[1]), 32'h11);
        wr_en = 1'b0;
        step();
        check("t3_next_b1", 32'(rda_o[0]), 32'h22);
        check("t3_next_b0", 32'(rda_o[1]), 32'h22);
        idle_in();

        // Out-of-range write and read on the 12-entry instance
        wr_en = 1'b1; wr_addr = 4'd13; wr_data = 8'h77;
        step();
        wr_en = 1'b0;
        check("t5_wr_err_d12", 32'(werr_o[2]), 1);
        check("t5_wr_err_d16", 32'(werr_o[0]), 0);
        rd_en_a = 1'b1; rd_addr_a = 4'd13;
        step();
        check("t5_rd13_d12", 32'(rda_o[2]), 0);
        check("t5_valid13_d12", 32'(va_o[2]), 1);
        check("t5_rd13_d16", 32'(rda_o[0]), 32'h77);
        rd_addr_a = 4'd3; rd_en_b = 1'b1; rd_addr_b = 4'd5;
        step();
        check("t5_rd3_d12", 32'(rda_o[2]), 32'hA5);
        check("t5_rd5_d12", 32'(rdb_o[2]), 32'h22);
        for (int a = 0; a < 12; a++) begin
            rd_addr_a = 4'(a); rd_addr_b = 4'(11 - a);
            step();
        end
        idle_in();

        // Fill with idx+1, then sweep
        for (int a = 0; a < 16; a++) begin
            wr_en = 1'b1; wr_addr = 4'(a); wr_data = 8'(a + 1);
            step();
        end
        wr_en = 1'b0;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        cnt = busy_o[0] ? 1 : 0;
        k = 0;
        while (busy_o[0] && k < 40) begin
            k++;
            idle_in();
            if (k == 3) clear_req = 1'b1;
            if (k == 4) begin rd_en_a = 1'b1; rd_addr_a = 4'd15; end
            if (k == 6) begin wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h99; end
            step();
            if (k == 4) check("t4_rd15_mid_sweep", 32'(rda_o[0]), 32'h10);
            if (k == 6) check("t4_wr_err_busy", 32'(werr_o[0]), 1);
            if (busy_o[0]) cnt++;
        end
        idle_in();
        check("t4_busy_cycles", 32'(cnt), 16);
        for (int a = 0; a < 16; a++) begin
            rd_en_a = 1'b1; rd_addr_a = 4'(a); rd_en_b = 1'b1; rd_addr_b = 4'(15 - a);
            step();
            check("t4_post_sweep_a", 32'(rda_o[0]), 0);
        end
        idle_in();

        // Reset in mid-sweep, then restart
        for (int a = 0; a < 16; a++) begin
            wr_en = 1'b1; wr_addr = 4'(a); wr_data = 8'h5A;
            step();
        end
        wr_en = 1'b0;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int c = 0; c < 6; c++) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("t6_busy_after_reset", 32'(busy_o[0]), 0);
        for (int a = 0; a < 16; a++) begin
            rd_en_a = 1'b1; rd_addr_a = 4'(a);
            step();
            check("t6_rd_after_reset", 32'(rda_o[0]), 0);
        end
        idle_in();
        for (int a = 0; a < 16; a++) begin
            wr_en = 1'b1; wr_addr = 4'(a); wr_data = 8'h3C;
            step();
        end
        wr_en = 1'b0;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check("t6_restart_busy", 32'(busy_o[0]), 1);
        step();
        rd_en_a = 1'b1; rd_addr_a = 4'd0; rd_en_b = 1'b1; rd_addr_b = 4'd1;
        step();
        check("t6_idx0_cleared", 32'(rda_o[0]), 0);
        check("t6_idx1_kept", 32'(rdb_o[0]), 32'h3C);
        idle_in();
        k = 0;
        while (busy_o[0] && k < 40) begin
            k++;
            step();
        end
        check("t6_sweep_done", 32'(busy_o[0]), 0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
